// File: rtl/enemy_array_draw_if.sv
// Pixel/ROM bus for enemy_array_draw.
//   master (renderer): drives rom_addr, enemy_rgb, enemy_hit; reads rom_data
//   slave  (ROM + colour mux): drives rom_data; reads the rest
//   rom_addr  : sprite ROM address, registered
//   rom_data  : ROM word, valid one cycle after rom_addr
//   enemy_rgb : pixel colour, MASK when transparent or no enemy
//   enemy_hit : high when enemy_rgb is an opaque enemy pixel
interface enemy_array_draw_if #(
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [11:0]           rom_data;
    logic [11:0]           enemy_rgb;
    logic                  enemy_hit;

    modport master (output rom_addr, enemy_rgb, enemy_hit, input rom_data);
    modport slave  (input rom_addr, enemy_rgb, enemy_hit, output rom_data);
endinterface

// File: rtl/enemy_array_draw.sv
// Enemy sprite renderer: N enemies sharing one external sprite ROM, with a
// shared walk animation and a per-enemy explosion sequence.
// Ports:
//   pixclk, rst      : pixel clock, synchronous active-high reset
//   draw_x, draw_y   : current scan position
//   frame_tick       : one pulse per video frame
//   enemy_pos_x/_y   : packed top-left positions (11/10 bits per enemy)
//   killed           : per-enemy kill level from game logic
//   bus              : ROM address/data and pixel output (see interface)
// Latency: draw_x/draw_y applied before edge t -> rom_addr after edge t,
// rom_data after t+1, enemy_rgb/enemy_hit after t+2 (three edges).
`ifndef MASK
`define MASK 12'hF0F
`endif

module enemy_array_draw #(
    parameter int N_ENEMIES     = 4,
    parameter int SPRITE_W      = 32,
    parameter int SPRITE_H      = 32,
    parameter int N_FRAMES      = 2,
    parameter int FRAME_PERIOD  = 8,
    parameter int EXPLODE_TICKS = 16,
    parameter int ADDR_WIDTH    = 16
) (
    input  logic                     pixclk,
    input  logic                     rst,
    input  logic [10:0]              draw_x,
    input  logic [9:0]               draw_y,
    input  logic                     frame_tick,
    input  logic [11*N_ENEMIES-1:0]  enemy_pos_x,
    input  logic [10*N_ENEMIES-1:0]  enemy_pos_y,
    input  logic [N_ENEMIES-1:0]     killed,
    enemy_array_draw_if.master       bus
);
    typedef enum logic [1:0] {ALIVE, EXPLODING, DEAD} estate_t;

    localparam int CW = $clog2(EXPLODE_TICKS + 1);
    localparam int TW = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
    localparam int FW = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
    localparam logic [11:0] W_M1 = 12'(SPRITE_W - 1);
    localparam logic [10:0] H_M1 = 11'(SPRITE_H - 1);

    estate_t                st_q   [N_ENEMIES];
    estate_t                st_d   [N_ENEMIES];
    logic [CW-1:0]          cnt_q  [N_ENEMIES];
    logic [CW-1:0]          cnt_d  [N_ENEMIES];
    logic [N_ENEMIES-1:0]   killed_q;
    logic [N_ENEMIES-1:0]   kill_rise;
    logic [TW-1:0]          tick_q;
    logic [FW-1:0]          frame_q;
    logic                   win;
    logic [ADDR_WIDTH-1:0]  addr_nx;
    logic [11:0]            dx12, px;
    logic [10:0]            dy11, py;
    logic [31:0]            img;
    logic [1:0]             vld_pipe;

    assign kill_rise = killed & ~killed_q;

    // Per-enemy state register
    always_ff @(posedge pixclk) begin
        if (rst) begin
            killed_q <= '0;
            for (int i = 0; i < N_ENEMIES; i++) begin
                st_q[i]  <= ALIVE;
                cnt_q[i] <= '0;
            end
        end else begin
            killed_q <= killed;
            for (int i = 0; i < N_ENEMIES; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Respawn has priority; a kill edge reloads the full explosion even when
    // frame_tick arrives in the same cycle, so that tick is not counted.
    always_comb begin
        for (int i = 0; i < N_ENEMIES; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];
            if (!killed[i]) begin
                st_d[i]  = ALIVE;
                cnt_d[i] = '0;
            end else if (kill_rise[i]) begin
                st_d[i]  = EXPLODING;
                cnt_d[i] = CW'(EXPLODE_TICKS);
            end else if (st_q[i] == EXPLODING && frame_tick) begin
                if (cnt_q[i] <= CW'(1)) begin
                    st_d[i]  = DEAD;
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] - CW'(1);
                end
            end
        end
    end

    // Shared walk animation
    always_ff @(posedge pixclk) begin
        if (rst) begin
            tick_q  <= '0;
            frame_q <= '0;
        end else if (frame_tick) begin
            if (tick_q == TW'(FRAME_PERIOD - 1)) begin
                tick_q  <= '0;
                frame_q <= (frame_q == FW'(N_FRAMES - 1)) ? '0 : frame_q + FW'(1);
            end else begin
                tick_q <= tick_q + TW'(1);
            end
        end
    end

    // Hit test in 12/11-bit so boxes near the right/bottom edge never wrap.
    // Scanning from the top index down leaves the lowest index as winner.
    always_comb begin
        win     = 1'b0;
        addr_nx = '0;
        dx12    = {1'b0, draw_x};
        dy11    = {1'b0, draw_y};
        px      = '0;
        py      = '0;
        img     = '0;
        for (int i = N_ENEMIES - 1; i >= 0; i--) begin
            px  = {1'b0, enemy_pos_x[11*i +: 11]};
            py  = {1'b0, enemy_pos_y[10*i +: 10]};
            img = (st_q[i] == EXPLODING) ? 32'(N_FRAMES) : 32'(frame_q);
            if (st_q[i] != DEAD && dx12 >= px && dx12 <= px + W_M1 &&
                dy11 >= py && dy11 <= py + H_M1) begin
                win     = 1'b1;
                addr_nx = ADDR_WIDTH'(img * 32'(SPRITE_W * SPRITE_H) +
                                      32'(dy11 - py) * 32'(SPRITE_W) +
                                      32'(dx12 - px));
            end
        end
    end

    // Address stage, valid delay to line up with rom_data, output stage
    always_ff @(posedge pixclk) begin
        if (rst) begin
            bus.rom_addr  <= '0;
            vld_pipe      <= '0;
            bus.enemy_rgb <= `MASK;
            bus.enemy_hit <= 1'b0;
        end else begin
            if (win)
                bus.rom_addr <= addr_nx;
            vld_pipe      <= {vld_pipe[0], win};
            bus.enemy_rgb <= vld_pipe[1] ? bus.rom_data : `MASK;
            bus.enemy_hit <= vld_pipe[1] && (bus.rom_data != `MASK);
        end
    end
endmodule

// File: tb/tb_enemy_array_draw.sv
module tb_enemy_array_draw;
    localparam logic [11:0] MASK = 12'hF0F;

    logic        pixclk;
    logic        rst;
    logic [10:0] draw_x;
    logic [9:0]  draw_y;
    logic        frame_tick;
    logic [43:0] pos_x;
    logic [39:0] pos_y;
    logic [3:0]  killed;
    logic [3:0]  kill_nxt;
    logic [15:0] mask_addr;
    int          checks;
    int          failures;

    typedef struct {
        logic        c;
        logic [11:0] rgb;
        logic        ca;
        logic [15:0] a;
        string       tag;
    } ent_t;

    ent_t q[$];
    ent_t aq[$];

    enemy_array_draw_if #(.ADDR_WIDTH(16)) bus ();

    enemy_array_draw dut (
        .pixclk      (pixclk),
        .rst         (rst),
        .draw_x      (draw_x),
        .draw_y      (draw_y),
        .frame_tick  (frame_tick),
        .enemy_pos_x (pos_x),
        .enemy_pos_y (pos_y),
        .killed      (killed),
        .bus         (bus)
    );

    initial pixclk = 1'b0;
    always #5 pixclk = ~pixclk;

    // Sprite ROM model: data is the low 12 address bits, one address forced to MASK
    always @(posedge pixclk)
        bus.rom_data <= (bus.rom_addr == mask_addr) ? MASK : bus.rom_addr[11:0];

    // One cycle: score outputs that are due, then drive and enqueue the next pixel.
    // rom_addr is due one edge after the pixel, enemy_rgb/hit three edges after.
    task automatic step(input logic [10:0] x, input logic [9:0] y, input logic tk,
                        input logic r, input logic c, input logic [11:0] rgb,
                        input logic ca, input logic [15:0] a, input string tag);
        ent_t e, o;
        logic want_hit;
        @(negedge pixclk);
        if (q.size() == 3) begin
            o = q.pop_front();
            if (o.c) begin
                want_hit = (o.rgb != MASK);
                checks++;
                if (bus.enemy_rgb !== o.rgb) begin
                    failures++;
                    $display("FAIL %s rgb: got %h want %h", o.tag, bus.enemy_rgb, o.rgb);
                end
                checks++;
                if (bus.enemy_hit !== want_hit) begin
                    failures++;
                    $display("FAIL %s hit: got %b want %b", o.tag, bus.enemy_hit, want_hit);
                end
            end
        end
        if (aq.size() == 1) begin
            o = aq.pop_front();
            if (o.ca) begin
                checks++;
                if (bus.rom_addr !== o.a) begin
                    failures++;
                    $display("FAIL %s rom_addr: got %0d want %0d", o.tag, bus.rom_addr, o.a);
                end
            end
        end
        draw_x     = x;
        draw_y     = y;
        frame_tick = tk;
        rst        = r;
        killed     = kill_nxt;
        e.c   = c | r;
        e.rgb = r ? MASK : rgb;
        e.ca  = ca | r;
        e.a   = r ? 16'd0 : a;
        e.tag = tag;
        q.push_back(e);
        aq.push_back(e);
    endtask

    task automatic idle(input int n, input logic tk);
        for (int k = 0; k < n; k++)
            step(11'd0, 10'd0, tk, 1'b0, 1'b0, 12'h0, 1'b0, 16'h0, "idle");
    endtask

    task automatic draw(input logic [10:0] x, input logic [9:0] y, input logic [11:0] rgb,
                        input logic ca, input logic [15:0] a, input string tag);
        step(x, y, 1'b0, 1'b0, 1'b1, rgb, ca, a, tag);
    endtask

    task automatic set_pos(input int i, input logic [10:0] x, input logic [9:0] y);
        pos_x[11*i +: 11] = x;
        pos_y[10*i +: 10] = y;
    endtask

    task automatic test_reset;
        for (int k = 0; k < 4; k++)
            step(11'd100, 10'd50, 1'b0, 1'b1, 1'b0, 12'h0, 1'b0, 16'h0, "reset");
        checks++;
        if (bus.enemy_rgb !== MASK) begin
            failures++;
            $display("FAIL reset_rgb: got %h want %h", bus.enemy_rgb, MASK);
        end
        checks++;
        if (bus.enemy_hit !== 1'b0) begin
            failures++;
            $display("FAIL reset_hit: got %b want 0", bus.enemy_hit);
        end
        checks++;
        if (bus.rom_addr !== 16'd0) begin
            failures++;
            $display("FAIL reset_addr: got %0d want 0", bus.rom_addr);
        end
    endtask

    task automatic test_single;
        draw(11'd100, 10'd50, 12'h000, 1'b1, 16'd0,    "single_tl");
        draw(11'd131, 10'd81, 12'h3FF, 1'b1, 16'd1023, "single_br");
        draw(11'd132, 10'd50, MASK,    1'b1, 16'd1023, "single_right_out");
        draw(11'd131, 10'd82, MASK,    1'b1, 16'd1023, "single_below_out");
        draw(11'd99,  10'd50, MASK,    1'b0, 16'd0,    "single_left_out");
        draw(11'd100, 10'd49, MASK,    1'b0, 16'd0,    "single_above_out");
        draw(11'd115, 10'd60, 12'h14F, 1'b1, 16'd335,  "single_mid");
        idle(4, 1'b0);
    endtask

    task automatic test_anim;
        idle(7, 1'b1);
        draw(11'd100, 10'd50, 12'h000, 1'b1, 16'd0,    "anim_7");
        idle(1, 1'b1);
        draw(11'd100, 10'd50, 12'h400, 1'b1, 16'd1024, "anim_8");
        idle(8, 1'b1);
        draw(11'd100, 10'd50, 12'h000, 1'b1, 16'd0,    "anim_16");
        idle(4, 1'b0);
    endtask

    task automatic test_kill;
        kill_nxt = 4'b0001;
        idle(1, 1'b0);
        draw(11'd100, 10'd50, 12'h800, 1'b1, 16'd2048, "kill_explode");
        idle(15, 1'b1);
        draw(11'd100, 10'd50, 12'h800, 1'b1, 16'd2048, "kill_15");
        idle(1, 1'b1);
        draw(11'd100, 10'd50, MASK,    1'b1, 16'd2048, "kill_dead");
        kill_nxt = 4'b0000;
        idle(1, 1'b0);
        draw(11'd100, 10'd50, 12'h000, 1'b1, 16'd0,    "kill_respawn");
        // abort mid-explosion
        kill_nxt = 4'b0001;
        idle(1, 1'b0);
        draw(11'd100, 10'd50, 12'h800, 1'b1, 16'd2048, "abort_explode");
        idle(3, 1'b1);
        kill_nxt = 4'b0000;
        idle(1, 1'b0);
        draw(11'd100, 10'd50, 12'h000, 1'b1, 16'd0,    "abort_alive");
        idle(4, 1'b0);
    endtask

    task automatic test_tick_coincide;
        kill_nxt = 4'b0001;
        idle(1, 1'b1);
        draw(11'd100, 10'd50, 12'h800, 1'b1, 16'd2048, "coin_explode");
        idle(15, 1'b1);
        draw(11'd100, 10'd50, 12'h800, 1'b1, 16'd2048, "coin_15");
        idle(1, 1'b1);
        draw(11'd100, 10'd50, MASK,    1'b1, 16'd2048, "coin_dead");
        kill_nxt = 4'b0000;
        idle(1, 1'b0);
        draw(11'd100, 10'd50, 12'h000, 1'b1, 16'd0,    "coin_respawn");
        idle(4, 1'b0);
    endtask

    task automatic test_overlap;
        set_pos(0, 11'd200, 10'd200);
        set_pos(1, 11'd190, 10'd190);
        mask_addr = 16'd0;
        idle(2, 1'b0);
        draw(11'd200, 10'd200, MASK,    1'b1, 16'd0,    "ovl_no_fallthru");
        draw(11'd195, 10'd195, 12'h0A5, 1'b1, 16'd165,  "ovl_e1_only");
        draw(11'd205, 10'd205, 12'h0A5, 1'b1, 16'd165,  "ovl_e0_wins");
        kill_nxt = 4'b0001;
        idle(1, 1'b0);
        draw(11'd200, 10'd200, 12'h800, 1'b1, 16'd2048, "ovl_e0_explode");
        idle(16, 1'b1);
        draw(11'd200, 10'd200, 12'h14A, 1'b1, 16'd330,  "ovl_e1_drawn");
        kill_nxt = 4'b0000;
        idle(1, 1'b0);
        mask_addr = 16'hFFFF;
        set_pos(1, 11'd1500, 10'd900);
        idle(4, 1'b0);
    endtask

    task automatic test_edge;
        set_pos(0, 11'd2016, 10'd50);
        idle(1, 1'b0);
        for (int x = 0; x <= 20; x++)
            draw(11'(x), 10'd50, MASK, 1'b0, 16'd0, "edge_no_wrap");
        draw(11'd2047, 10'd50, 12'h01F, 1'b1, 16'd31,   "edge_right");
        draw(11'd2047, 10'd81, 12'h3FF, 1'b1, 16'd1023, "edge_corner");
        draw(11'd2015, 10'd50, MASK,    1'b1, 16'd1023, "edge_left_out");
        idle(4, 1'b0);
        set_pos(0, 11'd100, 10'd50);
        idle(1, 1'b0);
    endtask

    task automatic test_reset_mid;
        idle(8, 1'b1);
        draw(11'd100, 10'd50, 12'h400, 1'b1, 16'd1024, "rmid_frame1");
        idle(3, 1'b0);
        for (int k = 0; k < 3; k++)
            step(11'(100 + k), 10'd50, 1'b0, 1'b1, 1'b1, MASK, 1'b1, 16'd0, "rmid_flush");
        for (int k = 3; k < 10; k++)
            draw(11'(100 + k), 10'd50, 12'(k), 1'b1, 16'(k), "rmid_after");
        idle(7, 1'b1);
        draw(11'd100, 10'd50, 12'h000, 1'b1, 16'd0,    "rmid_tick7");
        idle(1, 1'b1);
        draw(11'd100, 10'd50, 12'h400, 1'b1, 16'd1024, "rmid_tick8");
        idle(4, 1'b0);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        draw_x     = '0;
        draw_y     = '0;
        frame_tick = 1'b0;
        killed     = '0;
        kill_nxt   = '0;
        mask_addr  = 16'hFFFF;
        pos_x      = '0;
        pos_y      = '0;
        set_pos(0, 11'd100, 10'd50);
        for (int i = 1; i < 4; i++)
            set_pos(i, 11'd1500, 10'd900);
        test_reset();
        test_single();
        test_anim();
        test_kill();
        test_tick_coincide();
        test_overlap();
        test_edge();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end
endmodule
